// File: rtl/jx2_mem_port_arb_pkg.sv
// Shared definitions for the JX2 memory port arbiter: OK/status codes,
// FSM state encoding and requester IDs.
package jx2_mem_port_arb_pkg;

  localparam logic [1:0] UMEM_OK_READY = 2'h0;
  localparam logic [1:0] UMEM_OK_OK    = 2'h1;
  localparam logic [1:0] UMEM_OK_HOLD  = 2'h2;
  localparam logic [1:0] UMEM_OK_FAULT = 2'h3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GNT_IC  = 2'd1,
    ST_GNT_DC  = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } req_id_e;

  // A requester that is not being serviced is told to wait only while it asks.
  function automatic logic [1:0] holdIfOe(input logic oe);
    return oe ? UMEM_OK_HOLD : UMEM_OK_READY;
  endfunction

endpackage

// File: rtl/jx2_rr_arb2.sv
// Combinational two-way pick between I$ and D$: round-robin on ties,
// with an optional override that always favours the D$.
module jx2_rr_arb2
  import jx2_mem_port_arb_pkg::*;
#(
  parameter int unsigned PRIO_DC = 0
) (
  input  logic    icReq_i,
  input  logic    dcReq_i,
  input  req_id_e lastGnt_i,
  output logic    gntValid_o,
  output req_id_e gntId_o
);

  always_comb begin
    gntValid_o = icReq_i | dcReq_i;
    gntId_o    = REQ_IC;
    if (icReq_i && dcReq_i) begin
      gntId_o = ((PRIO_DC != 0) || (lastGnt_i == REQ_IC)) ? REQ_DC : REQ_IC;
    end else if (dcReq_i) begin
      gntId_o = REQ_DC;
    end
  end

endmodule

// File: rtl/jx2_mem_port_arb.sv
// Shares the single external memory port between the I$ and D$ using the
// OE/OK handshake, one transaction in flight, with a per-grant watchdog.
module jx2_mem_port_arb
  import jx2_mem_port_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned PRIO_DC = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] icAddr,
  input  logic              icOE,
  output logic [DATA_W-1:0] icData,
  output logic [1:0]        icOK,
  input  logic [ADDR_W-1:0] dcAddr,
  input  logic              dcOE,
  input  logic              dcWE,
  input  logic [DATA_W-1:0] dcDataIn,
  output logic [DATA_W-1:0] dcDataOut,
  output logic [1:0]        dcOK,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memOE,
  output logic              memWE,
  output logic [DATA_W-1:0] memDataOut,
  input  logic [DATA_W-1:0] memDataIn,
  input  logic [1:0]        memOK
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  arb_state_e        state_q;
  req_id_e           lastGnt_q;
  logic [7:0]        wdog_q;
  logic [7:0]        wdog_d;
  logic [ADDR_W-1:0] memAddr_q;
  logic              memOE_q;
  logic              memWE_q;
  logic [DATA_W-1:0] memDataOut_q;
  logic [DATA_W-1:0] icData_q;
  logic [DATA_W-1:0] dcData_q;
  logic [1:0]        icOK_q;
  logic [1:0]        dcOK_q;

  logic    gntValid;
  req_id_e gntId;
  logic    winIc;
  logic    winnerOe;

  jx2_rr_arb2 #(
    .PRIO_DC(PRIO_DC)
  ) u_rr (
    .icReq_i   (icOE),
    .dcReq_i   (dcOE),
    .lastGnt_i (lastGnt_q),
    .gntValid_o(gntValid),
    .gntId_o   (gntId)
  );

  // lastGnt always names the current owner once a grant has been made.
  assign winIc    = (lastGnt_q == REQ_IC);
  assign winnerOe = winIc ? icOE : dcOE;
  assign wdog_d   = wdog_q + 8'd1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      lastGnt_q    <= REQ_DC;
      wdog_q       <= '0;
      memAddr_q    <= '0;
      memOE_q      <= 1'b0;
      memWE_q      <= 1'b0;
      memDataOut_q <= '0;
      icData_q     <= '0;
      dcData_q     <= '0;
      icOK_q       <= UMEM_OK_READY;
      dcOK_q       <= UMEM_OK_READY;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Memory status is ignored here so a stale response cannot leak through.
          icOK_q <= holdIfOe(icOE);
          dcOK_q <= holdIfOe(dcOE);
          wdog_q <= '0;
          if (gntValid) begin
            state_q      <= (gntId == REQ_IC) ? ST_GNT_IC : ST_GNT_DC;
            lastGnt_q    <= gntId;
            memOE_q      <= 1'b1;
            memAddr_q    <= (gntId == REQ_IC) ? icAddr : dcAddr;
            memWE_q      <= (gntId == REQ_DC) && dcWE;
            memDataOut_q <= (gntId == REQ_DC) ? dcDataIn : '0;
          end
        end

        ST_GNT_IC, ST_GNT_DC: begin
          wdog_q <= wdog_d;
          if (winIc) dcOK_q <= holdIfOe(dcOE);
          else       icOK_q <= holdIfOe(icOE);
          if (!winnerOe) begin
            memOE_q <= 1'b0;
            memWE_q <= 1'b0;
            state_q <= ST_RELEASE;
            if (winIc) icOK_q <= UMEM_OK_READY;
            else       dcOK_q <= UMEM_OK_READY;
          end else if (memOK == UMEM_OK_OK) begin
            memOE_q <= 1'b0;
            memWE_q <= 1'b0;
            state_q <= ST_RELEASE;
            if (winIc) begin
              icOK_q   <= UMEM_OK_OK;
              icData_q <= memDataIn;
            end else begin
              dcOK_q   <= UMEM_OK_OK;
              dcData_q <= memDataIn;
            end
          end else if (wdog_d == TIMEOUT_CNT) begin
            memOE_q <= 1'b0;
            memWE_q <= 1'b0;
            state_q <= ST_RELEASE;
            if (winIc) icOK_q <= UMEM_OK_FAULT;
            else       dcOK_q <= UMEM_OK_FAULT;
          end else begin
            if (winIc) icOK_q <= UMEM_OK_HOLD;
            else       dcOK_q <= UMEM_OK_HOLD;
          end
        end

        ST_RELEASE: begin
          // Wait for memory to finish its handshake before re-arbitrating.
          wdog_q <= '0;
          if (winIc) dcOK_q <= holdIfOe(dcOE);
          else       icOK_q <= holdIfOe(icOE);
          if (!winnerOe) begin
            if (winIc) icOK_q <= UMEM_OK_READY;
            else       dcOK_q <= UMEM_OK_READY;
            if (memOK == UMEM_OK_READY) state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign memAddr    = memAddr_q;
  assign memOE      = memOE_q;
  assign memWE      = memWE_q;
  assign memDataOut = memDataOut_q;
  assign icData     = icData_q;
  assign dcDataOut  = dcData_q;
  assign icOK       = icOK_q;
  assign dcOK       = dcOK_q;

endmodule
